hidden_requant: RTL and testbench
=================================

// Module: hidden_requant
// PURPOSE
//  Downstream of the hidden layer. On the rising edge of the layer's all-done flag,
//  captures the packed ACC_W accumulators and processes one neuron per cycle:
//  ReLU, round, right shift, saturate to DATA_W. The packed result goes to the output
//  layer over a valid/ready handshake. A serial datapath keeps it to one requantiser.
// PARAMETERS
//  HIDDEN_SIZE  16  number of hidden neurons (>=2)
//  ACC_W        32  accumulator width per neuron, signed two's complement
//  DATA_W        8  output activation width, signed (result is always >=0)
//  FRAC_SHIFT    8  arithmetic right shift applied after rounding (0..ACC_W-2)
// PORTS
//  clk          in   1                   clock, all logic on rising edge
//  rst          in   1                   asynchronous, active-high reset
//  acc_in_flat  in   ACC_W*HIDDEN_SIZE   neuron i at [(i+1)*ACC_W-1 -: ACC_W]
//  acc_done     in   1                   level all-done from hidden layer
//  out_bus      out  DATA_W*HIDDEN_SIZE  activation i at [(i+1)*DATA_W-1 -: DATA_W]
//  out_valid    out  1                   out_bus holds a complete result
//  out_ready    in   1                   consumer accepts when out_valid&out_ready
//  busy         out  1                   high in PROC or HOLD
//  overrun      out  1                   sticky: an acc_done rise was dropped
// BEHAVIOUR
//  Reset (async assert): state=IDLE, idx=0, done_d=0, out_bus=0, out_valid=0,
//   busy=0, overrun=0. Outputs go to these values immediately, without waiting for clk.
//  done_rise = acc_done & ~done_d; done_d registers acc_done every cycle.
//   If acc_done stays high for several cycles, it is one event.
//  FSM:
//   IDLE: on done_rise, copy acc_in_flat into acc_buf, set idx=0, go to PROC.
//   PROC: requantise acc_buf[idx] into out_buf[idx], then idx++.
//    After idx==HIDDEN_SIZE-1, go to HOLD.
//   HOLD: out_valid=1 and out_bus is stable. On out_ready, go to IDLE.
//    If done_rise occurs in the same cycle as out_ready, capture and go
//    directly to PROC. This is not an overrun.
//  Any done_rise in PROC, or in HOLD without out_ready: event dropped, overrun<=1.
//   acc_buf and out_bus are unaffected.
//  out_bus is driven only from out_buf. out_buf changes only during PROC.
//  Latency: done_rise sampled at edge N -> out_valid=1 after edge N+HIDDEN_SIZE+1.
//   Throughput: at most one result per HIDDEN_SIZE+1 cycles.
//  Requantise element a (signed ACC_W):
//   if a<=0: result 0
//   else: compute t=(a + 2^(FRAC_SHIFT-1)) >>> FRAC_SHIFT in ACC_W+1 bits,
//    so the rounding add cannot wrap. The add is skipped when FRAC_SHIFT=0.
//    If t > 2^(DATA_W-1)-1, result is 2^(DATA_W-1)-1; else result is t[DATA_W-1:0].
//  busy = (state!=IDLE). out_valid = (state==HOLD), registered.
//  Reset in any state aborts the frame. No partial result is ever presented.
// TESTING  (defaults: HIDDEN_SIZE=16, FRAC_SHIFT=8, DATA_W=8)
//  1 Rounding/saturation: set neurons 0..5 = 384, -5, 0, 32639, 32640, 0x7FFFFFFF,
//    then pulse acc_done -> out_bus bytes 0..5 = 2, 0, 0, 127, 127, 127.
//  2 Latency: acc_done rises at edge 10 with out_ready=1 -> out_valid high after
//    edge 27 for exactly 1 cycle; busy high cycles 11..27.
//  3 Backpressure: hold out_ready=0 for 20 cycles -> out_bus is constant.
//    Raise acc_done during HOLD -> overrun=1, out_bus unchanged, still one
//    transfer when out_ready=1.
//  4 Back-to-back: in HOLD, assert out_ready and a new acc_done rise in the same
//    cycle -> overrun=0, busy stays 1, second result valid 17 cycles later.
//  5 Level input: hold acc_done high for 40 cycles -> exactly one capture and
//    one out_valid, overrun=0.
//  6 Reset mid-PROC: assert rst at idx=7 -> all outputs 0 with no clk edge.
//    After release, with no acc_done, out_valid stays 0 for 50 cycles.

Source files
------------

// File: rtl/hidden_requant.sv
// rtl/hidden_requant.sv - serial ReLU/round/shift/saturate requantiser between hidden and output layers
module hidden_requant #(
    parameter int HIDDEN_SIZE = 16,
    parameter int ACC_W       = 32,
    parameter int DATA_W      = 8,
    parameter int FRAC_SHIFT  = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [ACC_W*HIDDEN_SIZE-1:0]  acc_in_flat,
    input  logic                          acc_done,
    output logic [DATA_W*HIDDEN_SIZE-1:0] out_bus,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic                          busy,
    output logic                          overrun
);

    localparam int IDX_W = (HIDDEN_SIZE > 1) ? $clog2(HIDDEN_SIZE) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(HIDDEN_SIZE - 1);
    localparam logic [ACC_W:0] RND = (FRAC_SHIFT == 0) ? '0 :
        ((ACC_W+1)'(1) << ((FRAC_SHIFT == 0) ? 0 : FRAC_SHIFT - 1));
    localparam logic [ACC_W:0] SAT_MAX = (ACC_W+1)'((64'd1 << (DATA_W - 1)) - 64'd1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_PROC = 2'd1;
    localparam logic [1:0] S_HOLD = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              done_dly_q;
    logic              out_valid_q, out_valid_d;
    logic              overrun_q, overrun_d;
    logic [ACC_W-1:0]  acc_buf_q [HIDDEN_SIZE];
    logic [DATA_W-1:0] out_buf_q [HIDDEN_SIZE];

    logic done_rise, accept, capture, drop;

    assign done_rise = acc_done & ~done_dly_q;
    // Handshake only counts once out_valid is actually visible to the consumer.
    assign accept    = (state_q == S_HOLD) & out_valid_q & out_ready;
    assign capture   = done_rise & ((state_q == S_IDLE) | accept);
    assign drop      = done_rise & ~capture;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            S_IDLE: begin
                if (capture) begin
                    state_d = S_PROC;
                    idx_d   = '0;
                end
            end
            S_PROC: begin
                idx_d = idx_q + 1'b1;
                if (idx_q == LAST_IDX) begin
                    state_d = S_HOLD;
                    idx_d   = '0;
                end
            end
            S_HOLD: begin
                if (accept) begin
                    state_d = capture ? S_PROC : S_IDLE;
                    idx_d   = '0;
                end
            end
            default: begin
                state_d = S_IDLE;
                idx_d   = '0;
            end
        endcase
    end

    assign out_valid_d = (state_q == S_HOLD) & ~accept;
    assign overrun_d   = overrun_q | drop;

    logic [ACC_W-1:0]  req_a;
    logic [ACC_W:0]    req_t;
    logic [DATA_W-1:0] req_r;

    // Only positive values reach the shift, so zero extension is exact.
    always_comb begin
        req_a = acc_buf_q[idx_q];
        req_t = ({1'b0, req_a} + RND) >> FRAC_SHIFT;
        if (req_a[ACC_W-1] || (req_a == '0)) begin
            req_r = '0;
        end else if (req_t > SAT_MAX) begin
            req_r = SAT_MAX[DATA_W-1:0];
        end else begin
            req_r = req_t[DATA_W-1:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            done_dly_q  <= 1'b0;
            out_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
            for (int i = 0; i < HIDDEN_SIZE; i++) begin
                acc_buf_q[i] <= '0;
                out_buf_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            done_dly_q  <= acc_done;
            out_valid_q <= out_valid_d;
            overrun_q   <= overrun_d;
            if (capture) begin
                for (int i = 0; i < HIDDEN_SIZE; i++) begin
                    acc_buf_q[i] <= acc_in_flat[i*ACC_W +: ACC_W];
                end
            end
            if (state_q == S_PROC) begin
                out_buf_q[idx_q] <= req_r;
            end
        end
    end

    for (genvar g = 0; g < HIDDEN_SIZE; g++) begin : g_bus
        assign out_bus[g*DATA_W +: DATA_W] = out_buf_q[g];
    end

    assign out_valid = out_valid_q;
    assign busy      = (state_q != S_IDLE);
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_hidden_requant.sv
// tb/tb_hidden_requant.sv - directed and randomized checks of hidden_requant against an arithmetic model
module tb_hidden_requant;

    localparam int N  = 16;
    localparam int AW = 32;
    localparam int DW = 8;
    localparam int LAT = N + 1;

    logic              clk = 1'b0;
    logic              rst;
    logic [AW*N-1:0]   acc_in_flat;
    logic              acc_done;
    logic [DW*N-1:0]   out_bus;
    logic              out_valid;
    logic              out_ready;
    logic              busy;
    logic              overrun;

    int vectors = 0;
    int miscompares = 0;

    logic signed [AW-1:0] accs [N];
    logic [DW*N-1:0]      exp_bus;

    hidden_requant dut (
        .clk         (clk),
        .rst         (rst),
        .acc_in_flat (acc_in_flat),
        .acc_done    (acc_done),
        .out_bus     (out_bus),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .busy        (busy),
        .overrun     (overrun)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ReLU, round half up at 1/256, clamp to the largest positive byte.
    function automatic logic [DW-1:0] ref_q(input logic signed [AW-1:0] a);
        longint v;
        v = a;
        if (v <= 0) return '0;
        v = (v + 128) / 256;
        if (v > 127) v = 127;
        return DW'(v);
    endfunction

    function automatic logic signed [AW-1:0] rnd_acc();
        case ($urandom_range(0, 3))
            0:       return -AW'($urandom_range(0, 5000));
            1:       return AW'($urandom_range(0, 40000));
            2:       return AW'($urandom);
            default: return AW'($urandom_range(32000, 33000));
        endcase
    endfunction

    task automatic load_frame();
        for (int i = 0; i < N; i++) begin
            acc_in_flat[i*AW +: AW] = accs[i];
            exp_bus[i*DW +: DW]     = ref_q(accs[i]);
        end
    endtask

    task automatic random_frame();
        for (int i = 0; i < N; i++) accs[i] = rnd_acc();
        load_frame();
    endtask

    task automatic start_frame();
        acc_done = 1'b1;
        step();
        acc_done = 1'b0;
    endtask

    task automatic wait_valid(output int cnt);
        cnt = 0;
        while (out_valid !== 1'b1 && cnt < 100) begin
            step();
            cnt++;
        end
    endtask

    task automatic apply_reset();
        acc_done  = 1'b0;
        rst       = 1'b1;
        #1;
        check("async_rst_bus", out_bus, '0);
        check("async_rst_valid", out_valid, 0);
        check("async_rst_busy", busy, 0);
        check("async_rst_overrun", overrun, 0);
        step();
        rst = 1'b0;
        step();
    endtask

    int cnt;
    int vcount;
    logic [DW*N-1:0] held;
    logic [7:0] b;

    initial begin
        rst         = 1'b1;
        acc_done    = 1'b0;
        out_ready   = 1'b0;
        acc_in_flat = '0;
        #2;
        check("reset_bus", out_bus, '0);
        check("reset_valid", out_valid, 0);
        check("reset_busy", busy, 0);
        check("reset_overrun", overrun, 0);
        step();
        step();
        rst = 1'b0;
        step();

        // Rounding and saturation corners plus end-to-end latency.
        random_frame();
        accs[0] = 384;
        accs[1] = -5;
        accs[2] = 0;
        accs[3] = 32639;
        accs[4] = 32640;
        accs[5] = 32'h7FFF_FFFF;
        load_frame();
        out_ready = 1'b1;
        start_frame();
        check("busy_after_capture", busy, 1);
        wait_valid(cnt);
        check("latency", cnt, LAT);
        check("busy_in_hold", busy, 1);
        check("frame1_bus", out_bus, exp_bus);
        b = out_bus[7:0];   check("n0_384", b, 2);
        b = out_bus[15:8];  check("n1_neg", b, 0);
        b = out_bus[23:16]; check("n2_zero", b, 0);
        b = out_bus[31:24]; check("n3_32639", b, 127);
        b = out_bus[39:32]; check("n4_32640", b, 127);
        b = out_bus[47:40]; check("n5_max", b, 127);
        step();
        check("valid_one_cycle", out_valid, 0);
        check("idle_after_xfer", busy, 0);

        // Several randomized frames with immediate acceptance.
        for (int f = 0; f < 4; f++) begin
            random_frame();
            start_frame();
            wait_valid(cnt);
            check("rand_latency", cnt, LAT);
            check("rand_bus", out_bus, exp_bus);
            step();
            check("rand_valid_drop", out_valid, 0);
        end

        // Backpressure, plus a dropped done rise while holding.
        out_ready = 1'b0;
        random_frame();
        start_frame();
        wait_valid(cnt);
        check("bp_latency", cnt, LAT);
        check("bp_bus", out_bus, exp_bus);
        held = exp_bus;
        random_frame();
        for (int k = 0; k < 20; k++) begin
            acc_done = (k == 5);
            step();
            check("bp_bus_stable", out_bus, held);
            check("bp_valid_held", out_valid, 1);
        end
        acc_done = 1'b0;
        check("bp_overrun", overrun, 1);
        out_ready = 1'b1;
        step();
        check("bp_xfer", out_valid, 0);
        vcount = 0;
        for (int k = 0; k < 20; k++) begin
            step();
            if (out_valid === 1'b1) vcount++;
        end
        check("bp_single_xfer", vcount, 0);
        check("bp_bus_after", out_bus, held);

        apply_reset();

        // Back-to-back: accept and new capture in the same edge.
        out_ready = 1'b0;
        random_frame();
        start_frame();
        wait_valid(cnt);
        check("b2b_first_bus", out_bus, exp_bus);
        random_frame();
        out_ready = 1'b1;
        acc_done  = 1'b1;
        step();
        acc_done = 1'b0;
        check("b2b_valid_drop", out_valid, 0);
        check("b2b_busy", busy, 1);
        check("b2b_overrun", overrun, 0);
        wait_valid(cnt);
        check("b2b_latency", cnt, LAT);
        check("b2b_second_bus", out_bus, exp_bus);
        step();

        // Level-held done is a single event.
        random_frame();
        vcount = 0;
        acc_done = 1'b1;
        for (int k = 0; k < 40; k++) begin
            step();
            if (out_valid === 1'b1) begin
                vcount++;
                check("level_bus", out_bus, exp_bus);
            end
        end
        acc_done = 1'b0;
        check("level_one_valid", vcount, 1);
        check("level_overrun", overrun, 0);
        step();

        // Reset in the middle of processing.
        for (int i = 0; i < N; i++) accs[i] = AW'($urandom_range(1000, 30000));
        load_frame();
        start_frame();
        for (int k = 0; k < 7; k++) step();
        check("mid_busy", busy, 1);
        rst = 1'b1;
        #1;
        check("mid_rst_bus", out_bus, '0);
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_overrun", overrun, 0);
        step();
        rst = 1'b0;
        vcount = 0;
        for (int k = 0; k < 50; k++) begin
            step();
            if (out_valid === 1'b1) vcount++;
        end
        check("post_rst_quiet", vcount, 0);
        check("post_rst_busy", busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
